// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: PC / IF/ID / ID/EX control for load-use,
// taken-branch flush and data-memory miss freeze, plus saturating statistics.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic [4:0]       ex_rt_i,
    input  logic             ex_memread_i,
    input  logic             id_branch_taken_i,
    input  logic             dmem_miss_i,
    input  logic             dmem_ready_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_bubble_o,
    output logic             pipe_freeze_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_MISS = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_next;
    logic             w_lu;
    logic             w_flush_evt;
    logic             w_stall_evt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // r0 is hardwired zero, so a load targeting it can never create a hazard
    always_comb begin
        w_lu = ex_memread_i && (ex_rt_i != 5'd0) &&
               ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        pc_write_o     = 1'b0;
        if_id_write_o  = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_bubble_o = 1'b0;
        pipe_freeze_o  = 1'b0;
        w_flush_evt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if_id_flush_o  = 1'b1;
                id_ex_bubble_o = 1'b1;
                if (start_i) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                // a miss swallows any same-cycle LU or branch; both
                // re-evaluate once the memory stage drains
                if (dmem_miss_i) begin
                    pipe_freeze_o = 1'b1;
                    w_next        = S_MISS;
                end else if (w_lu) begin
                    id_ex_bubble_o = 1'b1;
                end else if (id_branch_taken_i) begin
                    pc_write_o    = 1'b1;
                    if_id_write_o = 1'b1;
                    if_id_flush_o = 1'b1;
                    w_flush_evt   = 1'b1;
                end else begin
                    pc_write_o    = 1'b1;
                    if_id_write_o = 1'b1;
                end
            end
            S_MISS: begin
                pipe_freeze_o = 1'b1;
                if (dmem_ready_i) begin
                    w_next = S_RUN;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_stall_evt = (r_state != S_IDLE) && !pc_write_o;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_evt && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (w_flush_evt && !(&r_flush_cnt)) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
        end
    end

    assign state_o     = r_state;
    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus pushes expected per-cycle
// response, a negedge monitor pops and compares (two counter widths).
module tb_hazard_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [4:0]  id_rs_i;
    logic [4:0]  id_rt_i;
    logic [4:0]  ex_rt_i;
    logic        ex_memread_i;
    logic        id_branch_taken_i;
    logic        dmem_miss_i;
    logic        dmem_ready_i;

    logic        pc_write_o, if_id_write_o, if_id_flush_o;
    logic        id_ex_bubble_o, pipe_freeze_o;
    logic [1:0]  state_o;
    logic [15:0] stall_cnt_o, flush_cnt_o;

    logic        s_pc_write, s_if_id_write, s_if_id_flush;
    logic        s_bubble, s_freeze;
    logic [1:0]  s_state;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    hazard_ctrl #(.CNT_W(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .ex_rt_i(ex_rt_i),
        .ex_memread_i(ex_memread_i),
        .id_branch_taken_i(id_branch_taken_i),
        .dmem_miss_i(dmem_miss_i), .dmem_ready_i(dmem_ready_i),
        .pc_write_o(pc_write_o), .if_id_write_o(if_id_write_o),
        .if_id_flush_o(if_id_flush_o), .id_ex_bubble_o(id_ex_bubble_o),
        .pipe_freeze_o(pipe_freeze_o), .state_o(state_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    hazard_ctrl #(.CNT_W(4)) dut_s (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .ex_rt_i(ex_rt_i),
        .ex_memread_i(ex_memread_i),
        .id_branch_taken_i(id_branch_taken_i),
        .dmem_miss_i(dmem_miss_i), .dmem_ready_i(dmem_ready_i),
        .pc_write_o(s_pc_write), .if_id_write_o(s_if_id_write),
        .if_id_flush_o(s_if_id_flush), .id_ex_bubble_o(s_bubble),
        .pipe_freeze_o(s_freeze), .state_o(s_state),
        .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt)
    );

    always #5 clk_i = ~clk_i;

    // {pc_write, if_id_write, if_id_flush, bubble, freeze}
    localparam logic [4:0] O_IDLE = 5'b00110;
    localparam logic [4:0] O_NORM = 5'b11000;
    localparam logic [4:0] O_LU   = 5'b00010;
    localparam logic [4:0] O_BR   = 5'b11100;
    localparam logic [4:0] O_FRZ  = 5'b00001;

    typedef struct {
        int         cyc;
        logic [4:0] ctl;
        logic [1:0] st;
        int         stall;
        int         flush;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    task automatic chk(input string nm, input int c,
                       input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL c%0d %s got=%0d exp=%0d", c, nm, got, exp);
        end
    endtask

    // monitor: outputs are valid every cycle, so pop whenever work is queued
    always @(negedge clk_i) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("ctl", e.cyc,
                int'({pc_write_o, if_id_write_o, if_id_flush_o,
                      id_ex_bubble_o, pipe_freeze_o}), int'(e.ctl));
            chk("state", e.cyc, int'(state_o), int'(e.st));
            chk("stall_cnt", e.cyc, int'(stall_cnt_o), e.stall);
            chk("flush_cnt", e.cyc, int'(flush_cnt_o), e.flush);
            chk("ctl_w4", e.cyc,
                int'({s_pc_write, s_if_id_write, s_if_id_flush,
                      s_bubble, s_freeze}), int'(e.ctl));
            chk("stall_cnt_w4", e.cyc, int'(s_stall_cnt),
                (e.stall > 15) ? 15 : e.stall);
        end
    end

    task automatic step(input logic rst, input logic start,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] exrt, input logic mrd,
                        input logic br, input logic miss,
                        input logic rdy, input logic [4:0] ctl,
                        input logic [1:0] st, input int stall,
                        input int flush);
        exp_t e;
        @(posedge clk_i);
        #2;
        rst_i = rst;
        start_i = start;
        id_rs_i = rs;
        id_rt_i = rt;
        ex_rt_i = exrt;
        ex_memread_i = mrd;
        id_branch_taken_i = br;
        dmem_miss_i = miss;
        dmem_ready_i = rdy;
        e.cyc = cyc;
        e.ctl = ctl;
        e.st = st;
        e.stall = stall;
        e.flush = flush;
        q.push_back(e);
        cyc++;
    endtask

    initial begin
        int to;
        rst_i = 1'b0;
        start_i = 1'b0;
        id_rs_i = '0;
        id_rt_i = '0;
        ex_rt_i = '0;
        ex_memread_i = 1'b0;
        id_branch_taken_i = 1'b0;
        dmem_miss_i = 1'b0;
        dmem_ready_i = 1'b0;

        //   rst st rs rt exrt mrd br ms rd  ctl    st  stall flush
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, O_IDLE, 0, 0, 0);
        step(1, 0, 1, 2, 3, 0, 0, 0, 0, O_NORM, 1, 0, 0);
        step(1, 0, 5, 2, 5, 1, 0, 0, 0, O_LU,   1, 0, 0);
        step(1, 0, 5, 2, 5, 0, 0, 0, 0, O_NORM, 1, 1, 0);
        step(1, 0, 0, 4, 0, 1, 0, 0, 0, O_NORM, 1, 1, 0);
        step(1, 0, 1, 2, 3, 0, 1, 0, 0, O_BR,   1, 1, 0);
        step(1, 0, 1, 2, 3, 0, 0, 0, 0, O_NORM, 1, 1, 1);
        step(1, 0, 1, 7, 7, 1, 1, 0, 0, O_LU,   1, 1, 1);
        step(1, 0, 1, 7, 7, 0, 0, 0, 0, O_NORM, 1, 2, 1);
        step(1, 0, 1, 2, 3, 0, 0, 1, 0, O_FRZ,  1, 2, 1);
        step(1, 0, 1, 2, 3, 0, 0, 0, 0, O_FRZ,  2, 3, 1);
        step(1, 0, 1, 2, 3, 0, 0, 0, 0, O_FRZ,  2, 4, 1);
        step(1, 0, 1, 2, 3, 0, 0, 0, 0, O_FRZ,  2, 5, 1);
        step(1, 0, 1, 2, 3, 0, 0, 0, 1, O_FRZ,  2, 6, 1);
        step(1, 0, 1, 2, 3, 0, 0, 0, 0, O_NORM, 1, 7, 1);
        step(0, 0, 1, 2, 3, 0, 0, 0, 0, O_IDLE, 0, 0, 0);
        step(1, 1, 1, 2, 3, 0, 0, 0, 0, O_IDLE, 0, 0, 0);
        step(1, 0, 1, 2, 3, 0, 0, 0, 0, O_NORM, 1, 0, 0);
        step(1, 0, 3, 2, 3, 1, 1, 1, 0, O_FRZ,  1, 0, 0);
        step(1, 0, 3, 2, 3, 1, 1, 1, 0, O_FRZ,  2, 1, 0);
        step(1, 0, 1, 2, 3, 0, 1, 0, 1, O_FRZ,  2, 2, 0);
        step(1, 0, 1, 2, 3, 0, 1, 0, 0, O_BR,   1, 3, 0);
        step(1, 0, 1, 2, 3, 0, 0, 1, 0, O_FRZ,  1, 3, 1);
        step(0, 0, 1, 2, 3, 0, 0, 0, 0, O_IDLE, 0, 0, 0);
        step(1, 0, 9, 9, 9, 1, 0, 0, 0, O_IDLE, 0, 0, 0);
        step(1, 1, 9, 9, 9, 1, 0, 0, 0, O_IDLE, 0, 0, 0);
        for (int k = 0; k < 20; k++) begin
            step(1, 0, 9, 9, 9, 1, 0, 0, 0, O_LU, 1, k, 0);
        end
        step(1, 0, 1, 2, 3, 0, 0, 0, 0, O_NORM, 1, 20, 0);

        to = 0;
        while (q.size() > 0 && to < 20) begin
            @(posedge clk_i);
            to++;
        end
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
